ysyx_22041752_bpu: RTL and testbench

Parametrised branch prediction unit for the ysyx_22041752 pipeline. It sits beside the fetch stage and predicts direction and target for conditional branches and JALR. Predictions come from a direct-mapped branch target buffer (BTB) with per-entry saturating direction counters. The execute stage trains the BTB from resolved outcomes (real taken flag, computed `bj_addr`, misprediction flag), and the unit keeps misprediction statistics.

---
 rtl/ysyx_22041752_bpu.sv | 133 +++++++++++++
 tb/tb_ysyx_22041752_bpu.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041752_bpu.sv
// Branch prediction unit: direct-mapped BTB with per-entry saturating direction
// counters, trained by the execute stage, plus misprediction statistics.
module ysyx_22041752_bpu #(
    parameter int unsigned PC_WD   = 32,
    parameter int unsigned ENTRIES = 8,
    parameter int unsigned CNT_WD  = 2,
    parameter int unsigned PERF_WD = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PC_WD-1:0]   fs_pc,
    output logic               pre_taken,
    output logic [PC_WD-1:0]   pre_target,
    input  logic               upd_valid,
    input  logic               upd_branch,
    input  logic               upd_jalr,
    input  logic [PC_WD-1:0]   upd_pc,
    input  logic               upd_taken,
    input  logic [PC_WD-1:0]   upd_target,
    input  logic               upd_pre_error,
    input  logic               bpu_clear,
    output logic [PERF_WD-1:0] perf_ctrl,
    output logic [PERF_WD-1:0] perf_miss
);

    localparam int unsigned IDX_WD = $clog2(ENTRIES);
    localparam int unsigned TAG_WD = PC_WD - IDX_WD - 2;
    localparam logic [CNT_WD-1:0] CNT_WEAK_T  = {1'b1, {(CNT_WD-1){1'b0}}};
    localparam logic [CNT_WD-1:0] CNT_WEAK_NT = {1'b0, {(CNT_WD-1){1'b1}}};

    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] jalr_q;
    logic [TAG_WD-1:0]  tag_q [ENTRIES];
    logic [PC_WD-1:0]   tgt_q [ENTRIES];
    logic [CNT_WD-1:0]  cnt_q [ENTRIES];

    logic [IDX_WD-1:0] rd_idx;
    logic [TAG_WD-1:0] rd_tag;
    logic              rd_hit;
    logic [IDX_WD-1:0] wr_idx;
    logic [TAG_WD-1:0] wr_tag;
    logic              wr_hit;
    logic              train;
    logic              wr_en;
    logic [PC_WD-1:0]  nxt_tgt;
    logic [CNT_WD-1:0] nxt_cnt;
    logic              nxt_jalr;
    logic              unused_pc_lsb;

    assign unused_pc_lsb = ^{fs_pc[1:0], upd_pc[1:0]};

    // Lookup reads the registered array only, so same-cycle training is not forwarded.
    assign rd_idx     = fs_pc[IDX_WD+1:2];
    assign rd_tag     = fs_pc[PC_WD-1:IDX_WD+2];
    assign rd_hit     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign pre_taken  = rd_hit && (jalr_q[rd_idx] || cnt_q[rd_idx][CNT_WD-1]);
    assign pre_target = pre_taken ? tgt_q[rd_idx] : fs_pc + PC_WD'(4);

    assign wr_idx = upd_pc[IDX_WD+1:2];
    assign wr_tag = upd_pc[PC_WD-1:IDX_WD+2];
    assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
    assign train  = upd_valid && (upd_branch || upd_jalr);

    // Next contents of the trained entry; JALR wins when both type flags are set.
    always_comb begin
        wr_en    = 1'b0;
        nxt_tgt  = tgt_q[wr_idx];
        nxt_cnt  = cnt_q[wr_idx];
        nxt_jalr = 1'b0;
        if (train) begin
            if (upd_jalr) begin
                wr_en    = 1'b1;
                nxt_tgt  = upd_target;
                nxt_cnt  = '1;
                nxt_jalr = 1'b1;
            end else if (wr_hit) begin
                wr_en = 1'b1;
                if (upd_taken) begin
                    nxt_tgt = upd_target;
                    if (cnt_q[wr_idx] != '1) begin
                        nxt_cnt = cnt_q[wr_idx] + CNT_WD'(1);
                    end
                end else if (cnt_q[wr_idx] != '0) begin
                    nxt_cnt = cnt_q[wr_idx] - CNT_WD'(1);
                end
            end else if (upd_taken) begin
                wr_en   = 1'b1;
                nxt_tgt = upd_target;
                nxt_cnt = CNT_WEAK_T;
            end
        end
    end

    // BTB array; a clear in the same cycle overrides the valid bit just written.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            jalr_q  <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                cnt_q[i] <= CNT_WEAK_NT;
            end
        end else begin
            if (wr_en) begin
                valid_q[wr_idx] <= 1'b1;
                jalr_q[wr_idx]  <= nxt_jalr;
                tag_q[wr_idx]   <= wr_tag;
                tgt_q[wr_idx]   <= nxt_tgt;
                cnt_q[wr_idx]   <= nxt_cnt;
            end
            if (bpu_clear) begin
                valid_q <= '0;
            end
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_ctrl <= '0;
            perf_miss <= '0;
        end else begin
            if (train && (perf_ctrl != '1)) begin
                perf_ctrl <= perf_ctrl + PERF_WD'(1);
            end
            if (upd_valid && upd_pre_error && (perf_miss != '1)) begin
                perf_miss <= perf_miss + PERF_WD'(1);
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22041752_bpu.sv
// Self-checking bench for ysyx_22041752_bpu: behavioural BTB model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_ysyx_22041752_bpu;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] fs_pc;
    logic        pre_taken,  pre_taken4;
    logic [31:0] pre_target, pre_target4;
    logic        upd_valid, upd_branch, upd_jalr, upd_taken, upd_pre_error, bpu_clear;
    logic [31:0] upd_pc, upd_target;
    logic [31:0] perf_ctrl, perf_miss;
    logic [3:0]  perf_ctrl4, perf_miss4;

    always #5 clk = ~clk;

    ysyx_22041752_bpu #(.PC_WD(32), .ENTRIES(8), .CNT_WD(2), .PERF_WD(32)) dut (
        .clk(clk), .reset(reset), .fs_pc(fs_pc),
        .pre_taken(pre_taken), .pre_target(pre_target),
        .upd_valid(upd_valid), .upd_branch(upd_branch), .upd_jalr(upd_jalr),
        .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pre_error(upd_pre_error), .bpu_clear(bpu_clear),
        .perf_ctrl(perf_ctrl), .perf_miss(perf_miss)
    );

    ysyx_22041752_bpu #(.PC_WD(32), .ENTRIES(8), .CNT_WD(2), .PERF_WD(4)) dut4 (
        .clk(clk), .reset(reset), .fs_pc(fs_pc),
        .pre_taken(pre_taken4), .pre_target(pre_target4),
        .upd_valid(upd_valid), .upd_branch(upd_branch), .upd_jalr(upd_jalr),
        .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pre_error(upd_pre_error), .bpu_clear(bpu_clear),
        .perf_ctrl(perf_ctrl4), .perf_miss(perf_miss4)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Model: one record per BTB slot; counter kept as a plain integer 0..3.
    bit          m_valid [8];
    bit          m_jalr  [8];
    logic [31:0] m_tag   [8];
    logic [31:0] m_tgt   [8];
    int          m_cnt   [8];
    longint      m_ctrl, m_miss;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint sat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic int slot(input logic [31:0] pc);
        return int'((pc >> 2) % 8);
    endfunction

    // Model update on each rising edge, from the inputs presented in that cycle.
    always @(posedge clk) begin
        int i;
        bit hit;
        if (reset) begin
            for (int k = 0; k < 8; k++) begin
                m_valid[k] = 0; m_jalr[k] = 0; m_tag[k] = 0; m_tgt[k] = 0; m_cnt[k] = 1;
            end
            m_ctrl = 0;
            m_miss = 0;
        end else begin
            if (upd_valid && upd_pre_error) m_miss++;
            if (upd_valid && (upd_branch || upd_jalr)) begin
                m_ctrl++;
                i   = slot(upd_pc);
                hit = m_valid[i] && (m_tag[i] == (upd_pc >> 5));
                if (upd_jalr) begin
                    m_valid[i] = 1; m_tag[i] = upd_pc >> 5; m_tgt[i] = upd_target;
                    m_cnt[i] = 3; m_jalr[i] = 1;
                end else if (hit) begin
                    m_jalr[i] = 0;
                    if (upd_taken) begin
                        m_tgt[i] = upd_target;
                        m_cnt[i] = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
                    end else begin
                        m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
                    end
                end else if (upd_taken) begin
                    m_valid[i] = 1; m_tag[i] = upd_pc >> 5; m_tgt[i] = upd_target;
                    m_cnt[i] = 2; m_jalr[i] = 0;
                end
            end
            if (bpu_clear) begin
                for (int k = 0; k < 8; k++) m_valid[k] = 0;
            end
        end
    end

    // Compare process on the falling edge.
    always @(negedge clk) begin
        int i;
        bit e_tk;
        logic [31:0] e_tg;
        if (chk_en) begin
            i    = slot(fs_pc);
            e_tk = m_valid[i] && (m_tag[i] == (fs_pc >> 5)) && (m_jalr[i] || m_cnt[i] >= 2);
            e_tg = e_tk ? m_tgt[i] : fs_pc + 32'd4;
            check("pre_taken",   64'(pre_taken),   64'(e_tk));
            check("pre_target",  64'(pre_target),  64'(e_tg));
            check("pre_taken4",  64'(pre_taken4),  64'(e_tk));
            check("pre_target4", 64'(pre_target4), 64'(e_tg));
            check("perf_ctrl",   64'(perf_ctrl),   64'(sat(m_ctrl, 32)));
            check("perf_miss",   64'(perf_miss),   64'(sat(m_miss, 32)));
            check("perf_ctrl4",  64'(perf_ctrl4),  64'(sat(m_ctrl, 4)));
            check("perf_miss4",  64'(perf_miss4),  64'(sat(m_miss, 4)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit b, input bit j, input logic [31:0] pc, input bit tk,
                         input logic [31:0] tgt, input bit err);
        upd_valid = 1'b1; upd_branch = b; upd_jalr = j; upd_pc = pc;
        upd_taken = tk; upd_target = tgt; upd_pre_error = err;
    endtask

    task automatic idle();
        upd_valid = 1'b0; upd_branch = 1'b0; upd_jalr = 1'b0; upd_pc = '0;
        upd_taken = 1'b0; upd_target = '0; upd_pre_error = 1'b0; bpu_clear = 1'b0;
    endtask

    task automatic train(input bit b, input bit j, input logic [31:0] pc, input bit tk,
                         input logic [31:0] tgt, input bit err);
        drive(b, j, pc, tk, tgt, err);
        tick();
        idle();
    endtask

    task automatic look(input string name, input logic [31:0] pc, input bit tk,
                        input logic [31:0] tgt);
        fs_pc = pc;
        #1;
        check({name, "_taken"},  64'(pre_taken),  64'(tk));
        check({name, "_target"}, 64'(pre_target), 64'(tgt));
    endtask

    initial begin
        idle();
        fs_pc = 32'h8000_0010;
        reset = 1'b1;
        tick();
        tick();
        reset  = 1'b0;
        chk_en = 1'b1;

        // 1: reset state
        look("s1", 32'h8000_0010, 1'b0, 32'h8000_0014);
        check("s1_ctrl", 64'(perf_ctrl), 64'd0);
        check("s1_miss", 64'(perf_miss), 64'd0);

        // 2: allocation, saturation up, then down to strongly not taken
        train(1, 0, 32'h8000_0010, 1, 32'h8000_0100, 1);
        look("s2_alloc", 32'h8000_0010, 1'b1, 32'h8000_0100);
        train(1, 0, 32'h8000_0010, 1, 32'h8000_0100, 0);
        train(1, 0, 32'h8000_0010, 1, 32'h8000_0100, 0);
        look("s2_sat", 32'h8000_0010, 1'b1, 32'h8000_0100);
        train(1, 0, 32'h8000_0010, 0, 32'h8000_0200, 1);
        look("s2_nt1", 32'h8000_0010, 1'b1, 32'h8000_0100);
        train(1, 0, 32'h8000_0010, 0, 32'h8000_0200, 1);
        look("s2_nt2", 32'h8000_0010, 1'b0, 32'h8000_0014);
        train(1, 0, 32'h8000_0010, 0, 32'h8000_0200, 0);
        look("s2_nt3", 32'h8000_0010, 1'b0, 32'h8000_0014);

        // 3: not-taken miss does not allocate, but is counted
        train(1, 0, 32'h8000_0020, 0, 32'h8000_0900, 0);
        look("s3", 32'h8000_0020, 1'b0, 32'h8000_0024);
        check("s3_ctrl", 64'(perf_ctrl), 64'd7);
        check("s3_miss", 64'(perf_miss), 64'd3);
        train(0, 0, 32'h8000_0020, 1, 32'h8000_0900, 1);
        check("s3_ctrl_notype", 64'(perf_ctrl), 64'd7);
        check("s3_miss_notype", 64'(perf_miss), 64'd4);

        // 4: JALR (with branch flag also set) and aliasing on index 1
        train(1, 1, 32'h8000_0024, 0, 32'h8000_2000, 1);
        look("s4_jalr", 32'h8000_0024, 1'b1, 32'h8000_2000);
        train(0, 1, 32'h8000_0044, 0, 32'h8000_3000, 0);
        look("s4_alias_old", 32'h8000_0024, 1'b0, 32'h8000_0028);
        look("s4_alias_new", 32'h8000_0044, 1'b1, 32'h8000_3000);

        // 5: same-cycle read/write, then clear racing a training event
        fs_pc = 32'h8000_0044;
        drive(0, 1, 32'h8000_0044, 0, 32'h8000_4000, 0);
        look("s5_old", 32'h8000_0044, 1'b1, 32'h8000_3000);
        tick();
        idle();
        look("s5_new", 32'h8000_0044, 1'b1, 32'h8000_4000);
        drive(1, 0, 32'h8000_0010, 1, 32'h8000_0500, 0);
        bpu_clear = 1'b1;
        tick();
        idle();
        look("s5_clr_a", 32'h8000_0010, 1'b0, 32'h8000_0014);
        look("s5_clr_b", 32'h8000_0044, 1'b0, 32'h8000_0048);
        look("s5_clr_c", 32'h8000_0024, 1'b0, 32'h8000_0028);

        // 6: reset discards a concurrent update; statistics saturate on the 4-bit unit
        reset = 1'b1;
        drive(0, 1, 32'h8000_0030, 0, 32'h8000_7000, 1);
        tick();
        idle();
        reset = 1'b0;
        look("s6_rst", 32'h8000_0030, 1'b0, 32'h8000_0034);
        check("s6_rst_ctrl", 64'(perf_ctrl), 64'd0);
        for (int n = 0; n < 20; n++) begin
            drive(1, 0, 32'h8000_0050, 0, 32'h8000_0800, 1);
            tick();
        end
        idle();
        tick();
        check("s6_ctrl4", 64'(perf_ctrl4), 64'hF);
        check("s6_miss4", 64'(perf_miss4), 64'hF);
        check("s6_ctrl",  64'(perf_ctrl),  64'd20);
        check("s6_miss",  64'(perf_miss),  64'd20);
        tick();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
